// File: rtl/counter_74ls161_pkg.sv
// Shared definitions for the 74LS161 counter slice: width, terminal value,
// and the per-bit next-state decode used by every stage.
package counter_74ls161_pkg;

  localparam int unsigned CNT_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] TERMINAL_COUNT = 4'b1111;

  // What a single bit stage does at the next rising clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_TOGGLE = 2'd1,
    ACT_LOAD   = 2'd2
  } stage_action_e;

  // Load wins over counting; a bit toggles only when counting is enabled
  // and every lower bit is already 1.
  function automatic stage_action_e stage_action(
    input logic load_n,
    input logic count_en,
    input logic carry_in
  );
    if (!load_n) begin
      return ACT_LOAD;
    end else if (count_en && carry_in) begin
      return ACT_TOGGLE;
    end
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/counter_74ls161_if.sv
// Pin bundle of the 74LS161: control, preset data, count outputs and TC.
// Clock and clear stay as plain ports on the counter.
interface counter_74ls161_if;
  logic PEn;
  logic CEP;
  logic CET;
  logic P0;
  logic P1;
  logic P2;
  logic P3;
  logic Q0;
  logic Q1;
  logic Q2;
  logic Q3;
  logic TC;

  // Board side: drives control/preset, observes count and TC.
  modport master (
    output PEn, CEP, CET, P0, P1, P2, P3,
    input  Q0, Q1, Q2, Q3, TC
  );

  // Counter side.
  modport slave (
    input  PEn, CEP, CET, P0, P1, P2, P3,
    output Q0, Q1, Q2, Q3, TC
  );
endinterface

// File: rtl/ls161_bit_stage.sv
// One bit of the 74LS161: a D flip-flop with asynchronous active-low clear
// and a load / toggle / hold next-state mux. The carry chain tells the stage
// whether all lower bits are 1.
module ls161_bit_stage
  import counter_74ls161_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic load_n,
  input  logic count_en,
  input  logic p,
  input  logic carry_in,
  output logic q,
  output logic carry_out
);

  logic q_reg;
  logic q_next;
  stage_action_e action;

  // Next-state mux: load preset, toggle on carry while counting, else hold.
  always_comb begin
    q_next = q_reg;
    action = stage_action(load_n, count_en, carry_in);
    case (action)
      ACT_LOAD:   q_next = p;
      ACT_TOGGLE: q_next = ~q_reg;
      default:    q_next = q_reg;
    endcase
  end

  // State flop; clear acts immediately, independent of the clock.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_reg <= 1'b0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q         = q_reg;
  assign carry_out = carry_in & q_reg;

endmodule

// File: rtl/counter_74ls161.sv
// 74LS161 4-bit synchronous presettable binary counter. Four bit stages share
// the clock and clear; the ripple-free carry chain feeds both the toggle
// decisions and the terminal-count gate.
module counter_74ls161
  import counter_74ls161_pkg::*;
(
  input  logic              CLK,
  input  logic              CLRn,
  counter_74ls161_if.slave  bus
);

  logic [CNT_WIDTH-1:0] p;
  logic [CNT_WIDTH-1:0] q;
  logic [CNT_WIDTH:0]   carry;
  logic                 count_en;

  assign p        = {bus.P3, bus.P2, bus.P1, bus.P0};
  assign count_en = bus.CEP & bus.CET;
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < CNT_WIDTH; gi++) begin : g_stage
      ls161_bit_stage u_stage (
        .clk       (CLK),
        .clr_n     (CLRn),
        .load_n    (bus.PEn),
        .count_en  (count_en),
        .p         (p[gi]),
        .carry_in  (carry[gi]),
        .q         (q[gi]),
        .carry_out (carry[gi+1])
      );
    end
  endgenerate

  assign bus.Q0 = q[0];
  assign bus.Q1 = q[1];
  assign bus.Q2 = q[2];
  assign bus.Q3 = q[3];

  // TC is purely combinational: CET gated with "all bits are 1".
  assign bus.TC = bus.CET & carry[CNT_WIDTH];

endmodule

// File: tb/tb_counter_74ls161.sv
// Directed bench for counter_74ls161. A behavioural model predicts Q/TC for
// every transaction; predictions are queued and popped when the DUT output is
// sampled just after the relevant edge or asynchronous event.
module tb_counter_74ls161;

  logic CLK;
  logic CLRn;
  counter_74ls161_if bus ();

  counter_74ls161 dut (
    .CLK  (CLK),
    .CLRn (CLRn),
    .bus  (bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [3:0]  m_q;
  logic [4:0]  sb[$];

  function automatic logic [3:0] p_val();
    return {bus.P3, bus.P2, bus.P1, bus.P0};
  endfunction

  function automatic logic [3:0] q_obs();
    return {bus.Q3, bus.Q2, bus.Q1, bus.Q0};
  endfunction

  task automatic set_p(input logic [3:0] v);
    bus.P0 = v[0];
    bus.P1 = v[1];
    bus.P2 = v[2];
    bus.P3 = v[3];
  endtask

  task automatic push_model();
    sb.push_back({m_q, bus.CET & (m_q == 4'hF)});
  endtask

  task automatic compare(input string tag);
    logic [4:0] exp_v;
    logic [4:0] obs_v;
    vectors++;
    obs_v = {q_obs(), bus.TC};
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed q=%b tc=%b", tag, obs_v[4:1], obs_v[0]);
    end else begin
      exp_v = sb.pop_front();
      assert (obs_v === exp_v) else begin
        miscompares++;
        $error("FAIL %s: observed q=%b tc=%b expected q=%b tc=%b",
               tag, obs_v[4:1], obs_v[0], exp_v[4:1], exp_v[0]);
      end
      $display("[%s] q=%b tc=%b", tag, obs_v[4:1], obs_v[0]);
    end
  endtask

  // Fixed-value check against a constant taken from the test plan.
  task automatic check_const(input string tag, input logic [3:0] eq, input logic etc);
    vectors++;
    assert ({q_obs(), bus.TC} === {eq, etc}) else begin
      miscompares++;
      $error("FAIL %s: observed q=%b tc=%b expected q=%b tc=%b",
             tag, q_obs(), bus.TC, eq, etc);
    end
  endtask

  // One full clock period; model updates on the rising edge, DUT sampled 1 after.
  task automatic edge_step(input string tag);
    if (CLRn) begin
      if (!bus.PEn) m_q = p_val();
      else if (bus.CEP && bus.CET) m_q = m_q + 4'd1;
    end
    push_model();
    CLK = 1'b1;
    #1;
    compare(tag);
    #4;
    CLK = 1'b0;
    #5;
  endtask

  // Asynchronous/combinational check with no clock edge.
  task automatic expect_now(input string tag);
    if (!CLRn) m_q = 4'h0;
    push_model();
    #1;
    compare(tag);
  endtask

  initial begin
    CLK     = 1'b0;
    CLRn    = 1'b1;
    bus.PEn = 1'b1;
    bus.CEP = 1'b1;
    bus.CET = 1'b1;
    set_p(4'h0);
    m_q = 4'h0;
    #10;

    // 1. Clear with the clock idle.
    CLRn = 1'b0;
    expect_now("clr_low");
    check_const("clr_low_const", 4'h0, 1'b0);
    #4;
    CLRn = 1'b1;
    expect_now("clr_release");

    // 2. Count 40 edges with wrap.
    for (int i = 0; i < 40; i++) edge_step("count");
    check_const("count40_end", 4'h8, 1'b0);

    // 3. Load all ones, then count 8.
    set_p(4'hF);
    bus.PEn = 1'b0;
    edge_step("load_f");
    check_const("load_f_const", 4'hF, 1'b1);
    bus.PEn = 1'b1;
    for (int i = 0; i < 8; i++) edge_step("count_from_f");
    check_const("from_f_end", 4'h7, 1'b0);

    // 4. Load a mid value, then count 8.
    set_p(4'h6);
    bus.PEn = 1'b0;
    edge_step("load_6");
    bus.PEn = 1'b1;
    for (int i = 0; i < 8; i++) edge_step("count_from_6");
    check_const("from_6_end", 4'hE, 1'b0);

    // 5. Enables at terminal count.
    edge_step("to_15");
    bus.CEP = 1'b0;
    edge_step("cep0_hold");
    check_const("cep0_tc", 4'hF, 1'b1);
    bus.CET = 1'b0;
    expect_now("cet0_tc_comb");
    edge_step("cet0_hold");
    set_p(4'h3);
    bus.PEn = 1'b0;
    edge_step("load_no_enable");
    check_const("load_no_enable_const", 4'h3, 1'b0);

    // 6. Async clear mid-count.
    set_p(4'h9);
    edge_step("load_9");
    bus.PEn = 1'b1;
    bus.CEP = 1'b1;
    bus.CET = 1'b1;
    #2;
    CLRn = 1'b0;
    expect_now("async_clr");
    for (int i = 0; i < 3; i++) edge_step("clr_held");
    CLRn = 1'b1;
    #1;
    edge_step("after_clr");
    check_const("after_clr_const", 4'h1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
